// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes one RV32I instruction into ALU operands and
// a 6-bit mode, then holds it in a single registered slot with a valid/ready handshake.
module alu_issue_stage #(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [WordSize-1:0] in_pc,
  input  logic [WordSize-1:0] in_rs1,
  input  logic [WordSize-1:0] in_rs2,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordSize-1:0] alu_a,
  output logic [WordSize-1:0] alu_b,
  output logic [5:0]          alu_mode,
  output logic [4:0]          out_rd,
  output logic                out_rd_we,
  output logic                out_illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  logic                out_valid_r;
  logic [WordSize-1:0] alu_a_r;
  logic [WordSize-1:0] alu_b_r;
  logic [5:0]          alu_mode_r;
  logic [4:0]          out_rd_r;
  logic                out_rd_we_r;
  logic                out_illegal_r;

  logic                in_ready_s;
  logic                accept_s;
  logic [6:0]          opcode_s;
  logic [2:0]          funct3_s;
  logic [6:0]          funct7_s;
  logic [4:0]          rd_s;
  logic signed [11:0]  imm_i12_s;
  logic signed [11:0]  imm_s12_s;
  logic signed [31:0]  imm_u32_s;
  logic [WordSize-1:0] imm_i_s;
  logic [WordSize-1:0] imm_st_s;
  logic [WordSize-1:0] imm_u_s;
  logic [WordSize-1:0] dec_a_s;
  logic [WordSize-1:0] dec_b_s;
  logic [5:0]          dec_mode_s;
  logic                dec_we_s;
  logic                dec_illegal_s;

  // Field extraction and sign-extended immediates
  always_comb begin
    opcode_s  = in_instr[6:0];
    funct3_s  = in_instr[14:12];
    funct7_s  = in_instr[31:25];
    rd_s      = in_instr[11:7];
    imm_i12_s = in_instr[31:20];
    imm_s12_s = {in_instr[31:25], in_instr[11:7]};
    imm_u32_s = {in_instr[31:12], 12'h000};
    imm_i_s   = WordSize'(imm_i12_s);
    imm_st_s  = WordSize'(imm_s12_s);
    imm_u_s   = WordSize'(imm_u32_s);
  end

  // Opcode decode into operands, mode and writeback enable; illegal forces a neutral op
  always_comb begin
    dec_a_s       = {WordSize{1'b0}};
    dec_b_s       = {WordSize{1'b0}};
    dec_mode_s    = 6'h00;
    dec_we_s      = (rd_s != 5'd0);
    dec_illegal_s = 1'b0;
    case (opcode_s)
      OpcOp: begin
        dec_a_s = in_rs1;
        dec_b_s = in_rs2;
        if (funct7_s == 7'b0000000) begin
          dec_mode_s = {1'b0, 2'b00, funct3_s};
        end else if ((funct7_s == 7'b0100000) &&
                     ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          dec_mode_s = {1'b1, 2'b00, funct3_s};
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      OpcOpImm: begin
        dec_a_s = in_rs1;
        dec_b_s = imm_i_s;
        if (funct3_s == 3'b001) begin
          dec_mode_s    = {1'b0, 2'b00, funct3_s};
          dec_illegal_s = (funct7_s != 7'b0000000);
        end else if (funct3_s == 3'b101) begin
          dec_mode_s    = {in_instr[30], 2'b00, funct3_s};
          dec_illegal_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
        end else begin
          dec_mode_s = {1'b0, 2'b00, funct3_s};
        end
      end
      OpcLui: begin
        dec_b_s = imm_u_s;
      end
      OpcAuipc: begin
        dec_a_s = in_pc;
        dec_b_s = imm_u_s;
      end
      OpcLoad: begin
        dec_a_s = in_rs1;
        dec_b_s = imm_i_s;
      end
      OpcStore: begin
        dec_a_s  = in_rs1;
        dec_b_s  = imm_st_s;
        dec_we_s = 1'b0;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
    if (dec_illegal_s) begin
      dec_a_s    = {WordSize{1'b0}};
      dec_b_s    = {WordSize{1'b0}};
      dec_mode_s = 6'h00;
      dec_we_s   = 1'b0;
    end else begin
      dec_mode_s = dec_mode_s;
    end
  end

  // Handshake: no skid buffer, so readiness follows the slot and downstream directly
  always_comb begin
    in_ready_s = rstn & ~flush & (~out_valid_r | out_ready);
    accept_s   = in_valid & in_ready_s;
  end

  // Single-entry issue slot; flush beats accept, accept beats drain
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_r   <= 1'b0;
      alu_a_r       <= {WordSize{1'b0}};
      alu_b_r       <= {WordSize{1'b0}};
      alu_mode_r    <= 6'h00;
      out_rd_r      <= 5'd0;
      out_rd_we_r   <= 1'b0;
      out_illegal_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      alu_a_r       <= dec_a_s;
      alu_b_r       <= dec_b_s;
      alu_mode_r    <= dec_mode_s;
      out_rd_r      <= rd_s;
      out_rd_we_r   <= dec_we_s;
      out_illegal_r <= dec_illegal_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_mode    = alu_mode_r;
  assign out_rd      = out_rd_r;
  assign out_rd_we   = out_rd_we_r;
  assign out_illegal = out_illegal_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-computed decode results, handshake,
// backpressure, flush and reset behaviour.
module tb_alu_issue_stage;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_mode;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.WordSize(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] m, input logic [4:0] rd,
                         input logic we, input logic ill);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_a"}, alu_a, a);
    chk({tag, "_b"}, alu_b, b);
    chk({tag, "_mode"}, {26'd0, alu_mode}, {26'd0, m});
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, "_we"}, {31'd0, out_rd_we}, {31'd0, we});
    chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    in_rs1 = 32'h0; in_rs2 = 32'h0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 1'b0, 1'b0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // SUB x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h402081B3; in_rs1 = 32'd10; in_rs2 = 32'd3;
    tick();
    chk_out("sub", 1'b1, 32'd10, 32'd3, 6'h20, 5'd3, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("sub_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("sub_drain_hold_mode", {26'd0, alu_mode}, 32'h20);

    // SRAI x5,x6,4 then ADDI x1,x0,-1 back to back
    in_valid = 1'b1; in_instr = 32'h40435293; in_rs1 = 32'hF0000000;
    tick();
    chk("srai_mode", {26'd0, alu_mode}, 32'h25);
    chk("srai_a", alu_a, 32'hF0000000);
    chk("srai_shamt", {27'd0, alu_b[4:0]}, 32'd4);
    chk("srai_rd", {27'd0, out_rd}, 32'd5);
    in_instr = 32'hFFF00093; in_rs1 = 32'h0;
    tick();
    chk_out("addi", 1'b1, 32'h0, 32'hFFFFFFFF, 6'h00, 5'd1, 1'b1, 1'b0);

    // ADDI x0,x0,1: rd=0 disables writeback
    in_instr = 32'h00100013;
    tick();
    chk_out("addi_x0", 1'b1, 32'h0, 32'h1, 6'h00, 5'd0, 1'b0, 1'b0);

    // LUI x8,0xFFFFF
    in_instr = 32'hFFFFF437; in_rs1 = 32'h12345678;
    tick();
    chk_out("lui", 1'b1, 32'h0, 32'hFFFFF000, 6'h00, 5'd8, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();

    // Backpressure: A = ADD x4,x1,x2 held while B = XOR x6,x1,x2 waits
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h00208233; in_rs1 = 32'd5; in_rs2 = 32'd7;
    tick();
    in_instr = 32'h0020C333; in_rs1 = 32'h000000AA; in_rs2 = 32'h00000055;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk_out("bp_hold", 1'b1, 32'd5, 32'd7, 6'h00, 5'd4, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("xor", 1'b1, 32'h000000AA, 32'h00000055, 6'h04, 5'd6, 1'b1, 1'b0);

    // Illegal opcode, then OP with funct7=0000001
    in_instr = 32'h0000007F; in_rs1 = 32'h11111111; in_rs2 = 32'h22222222;
    tick();
    chk_out("ill_opc", 1'b1, 32'h0, 32'h0, 6'h00, 5'd0, 1'b0, 1'b1);
    in_instr = 32'h022081B3;
    tick();
    chk_out("ill_f7", 1'b1, 32'h0, 32'h0, 6'h00, 5'd3, 1'b0, 1'b1);

    // Flush with slot valid and a legal instruction offered
    in_instr = 32'h00208233; in_rs1 = 32'd5; in_rs2 = 32'd7; flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_discard", {31'd0, out_illegal}, 32'd1);
    flush = 1'b0;

    // AUIPC x7,0x12345 at pc 0x100
    in_instr = 32'h12345397; in_pc = 32'h00000100;
    tick();
    chk_out("auipc", 1'b1, 32'h00000100, 32'h12345000, 6'h00, 5'd7, 1'b1, 1'b0);

    // SW x2,8(x1)
    in_instr = 32'h0020A423; in_rs1 = 32'h00001000;
    tick();
    chk_out("sw", 1'b1, 32'h00001000, 32'h00000008, 6'h00, 5'd8, 1'b0, 1'b0);

    // Reset while holding a valid instruction
    in_valid = 1'b0; out_ready = 1'b0; rstn = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("midrst", 1'b0, 32'h0, 32'h0, 6'h00, 5'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
